// File: rtl/ps2_key_decoder_pkg.sv
// Shared scancode constants and prefix-FSM encoding
// for the PS/2 set-2 keyboard decode path.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_ECHO    = 8'hEE;
  localparam logic [7:0] SC_BAT_ERR = 8'hFC;
  localparam logic [7:0] SC_RESEND  = 8'hFE;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Keyboard-to-host responses carry no key information.
  function automatic logic is_response(
    input logic [7:0] c
  );
    return (c == SC_BAT_OK) || (c == SC_ACK)
        || (c == SC_ECHO) || (c == SC_BAT_ERR)
        || (c == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / character-out bundle between the
// PS/2 receiver, the decoder and its consumers.
interface ps2_key_decoder_if #(
  parameter int FIFO_DEPTH = 4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    code_in;
  logic          code_valid;
  logic          rd_en;
  logic [7:0]    ascii_out;
  logic          ascii_valid;
  logic [CW-1:0] fifo_count;
  logic          shift_active;
  logic          overflow;

  modport master (
    output code_in,
    output code_valid,
    output rd_en,
    input  ascii_out,
    input  ascii_valid,
    input  fifo_count,
    input  shift_active,
    input  overflow
  );

  modport slave (
    input  code_in,
    input  code_valid,
    input  rd_en,
    output ascii_out,
    output ascii_valid,
    output fifo_count,
    output shift_active,
    output overflow
  );

endinterface

// File: rtl/ps2_key_decoder_ascii.sv
// Combinational set-2 scancode to ASCII lookup.
// Returns 8'h00 for codes with no printable mapping.
module ps2_to_ascii (
  input  logic [7:0] char_in,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic [7:0] upper;
  logic       letter;

  always_comb begin
    lower  = 8'h00;
    upper  = 8'h00;
    letter = 1'b0;
    case (char_in)
      8'h1C: begin lower = "a"; letter = 1'b1; end
      8'h32: begin lower = "b"; letter = 1'b1; end
      8'h21: begin lower = "c"; letter = 1'b1; end
      8'h23: begin lower = "d"; letter = 1'b1; end
      8'h24: begin lower = "e"; letter = 1'b1; end
      8'h2B: begin lower = "f"; letter = 1'b1; end
      8'h34: begin lower = "g"; letter = 1'b1; end
      8'h33: begin lower = "h"; letter = 1'b1; end
      8'h43: begin lower = "i"; letter = 1'b1; end
      8'h3B: begin lower = "j"; letter = 1'b1; end
      8'h42: begin lower = "k"; letter = 1'b1; end
      8'h4B: begin lower = "l"; letter = 1'b1; end
      8'h3A: begin lower = "m"; letter = 1'b1; end
      8'h31: begin lower = "n"; letter = 1'b1; end
      8'h44: begin lower = "o"; letter = 1'b1; end
      8'h4D: begin lower = "p"; letter = 1'b1; end
      8'h15: begin lower = "q"; letter = 1'b1; end
      8'h2D: begin lower = "r"; letter = 1'b1; end
      8'h1B: begin lower = "s"; letter = 1'b1; end
      8'h2C: begin lower = "t"; letter = 1'b1; end
      8'h3C: begin lower = "u"; letter = 1'b1; end
      8'h2A: begin lower = "v"; letter = 1'b1; end
      8'h1D: begin lower = "w"; letter = 1'b1; end
      8'h22: begin lower = "x"; letter = 1'b1; end
      8'h35: begin lower = "y"; letter = 1'b1; end
      8'h1A: begin lower = "z"; letter = 1'b1; end
      8'h45: begin lower = "0"; upper = ")"; end
      8'h16: begin lower = "1"; upper = "!"; end
      8'h1E: begin lower = "2"; upper = "@"; end
      8'h26: begin lower = "3"; upper = "#"; end
      8'h25: begin lower = "4"; upper = "$"; end
      8'h2E: begin lower = "5"; upper = "%"; end
      8'h36: begin lower = "6"; upper = "^"; end
      8'h3D: begin lower = "7"; upper = "&"; end
      8'h3E: begin lower = "8"; upper = "*"; end
      8'h46: begin lower = "9"; upper = "("; end
      8'h4E: begin lower = "-"; upper = "_"; end
      8'h55: begin lower = "="; upper = "+"; end
      8'h41: begin lower = ","; upper = "<"; end
      8'h49: begin lower = "."; upper = ">"; end
      8'h4A: begin lower = "/"; upper = "?"; end
      8'h29: begin lower = " "; upper = " "; end
      8'h5A: begin lower = 8'h0D; upper = 8'h0D; end
      8'h66: begin lower = 8'h08; upper = 8'h08; end
      8'h0D: begin lower = 8'h09; upper = 8'h09; end
      default: ;
    endcase
    if (letter) upper = lower - 8'h20;
  end

  assign ascii = shift ? upper : lower;

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 make/break/extended sequencer with shift
// tracking and a small character FIFO on the output.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              rst,
  ps2_key_decoder_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]    state, state_d;
  logic          lshift, lshift_d;
  logic          rshift, rshift_d;
  logic [TW-1:0] idle_cnt;
  logic          make, tmo;
  logic [7:0]    lut_ascii;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, push, push_ok, pop_ok;
  logic          ovf;

  wire [7:0] code = bus.code_in;
  wire       cv   = bus.code_valid;

  wire st_idle    = state == ST_IDLE;
  wire st_ext     = state == ST_EXT;
  wire st_brk     = state == ST_BRK;
  wire st_ext_brk = state == ST_EXT_BRK;

  ps2_to_ascii u_lut (
    .char_in (code),
    .shift   (lshift | rshift),
    .ascii   (lut_ascii)
  );

  assign tmo = !st_idle && !cv
            && idle_cnt == TW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d  = state;
    lshift_d = lshift;
    rshift_d = rshift;
    make     = 1'b0;
    if (cv) begin
      unique case (1'b1)
        st_idle: begin
          if (code == SC_EXT)
            state_d = ST_EXT;
          else if (code == SC_BREAK)
            state_d = ST_BRK;
          else if (code == SC_LSHIFT)
            lshift_d = 1'b1;
          else if (code == SC_RSHIFT)
            rshift_d = 1'b1;
          else if (!is_response(code))
            make = 1'b1;
        end
        st_brk: begin
          if (code == SC_LSHIFT) lshift_d = 1'b0;
          if (code == SC_RSHIFT) rshift_d = 1'b0;
          state_d = ST_IDLE;
        end
        st_ext: begin
          state_d = (code == SC_BREAK)
                  ? ST_EXT_BRK : ST_IDLE;
        end
        st_ext_brk: state_d = ST_IDLE;
      endcase
    end else if (tmo) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state  <= state_d;
      lshift <= lshift_d;
      rshift <= rshift_d;
      if (cv || st_idle || tmo)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // A full FIFO still accepts a push when the head is popped.
  assign full    = count == CW'(FIFO_DEPTH);
  assign push    = make && (lut_ascii != 8'h00);
  assign pop_ok  = bus.rd_en && (count != '0);
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 8'h00;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= lut_ascii;
        wptr      <= wptr + PW'(1);
      end
      if (pop_ok)
        rptr <= rptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
      ovf   <= push && !push_ok;
    end
  end

  assign bus.ascii_out    = (count != '0)
                          ? mem[rptr] : 8'h00;
  assign bus.ascii_valid  = count != '0;
  assign bus.fifo_count   = count;
  assign bus.shift_active = lshift | rshift;
  assign bus.overflow     = ovf;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with
// FIFO_DEPTH=4 and TIMEOUT_CYCLES=8.
module tb_ps2_key_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ps2_key_decoder_if #(.FIFO_DEPTH(4)) bus ();

  ps2_key_decoder #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.code_in    = b;
    bus.code_valid = 1'b1;
    cyc();
    bus.code_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  initial begin
    bus.code_in    = 8'h00;
    bus.code_valid = 1'b0;
    bus.rd_en      = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_valid", bus.ascii_valid, 0);
    chk("rst_out", bus.ascii_out, 8'h00);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_shift", bus.shift_active, 0);
    chk("rst_ovf", bus.overflow, 0);

    send(8'h16);
    chk("mk1_out", bus.ascii_out, 8'h31);
    chk("mk1_valid", bus.ascii_valid, 1);
    chk("mk1_count", bus.fifo_count, 1);
    pop1();
    chk("pop_count", bus.fifo_count, 0);
    chk("pop_out", bus.ascii_out, 8'h00);
    chk("pop_valid", bus.ascii_valid, 0);

    send(8'h12);
    chk("lsh_on", bus.shift_active, 1);
    send(8'h16);
    chk("lsh_bang", bus.ascii_out, 8'h21);
    send(8'hF0);
    chk("brk_hold", bus.shift_active, 1);
    send(8'h12);
    chk("lsh_off", bus.shift_active, 0);
    pop1();

    send(8'h59);
    chk("rsh_on", bus.shift_active, 1);
    send(8'h1C);
    chk("rsh_A", bus.ascii_out, 8'h41);
    pop1();
    send(8'hF0);
    send(8'h59);
    chk("rsh_off", bus.shift_active, 0);
    send(8'h1C);
    chk("lower_a", bus.ascii_out, 8'h61);
    pop1();

    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h12);
    send(8'hE0); send(8'h16);
    chk("ext_count", bus.fifo_count, 0);
    chk("ext_shift", bus.shift_active, 0);
    send(8'h16);
    chk("ext_idle", bus.ascii_out, 8'h31);
    pop1();

    send(8'hAA);
    send(8'hFA);
    chk("resp_ign", bus.fifo_count, 0);

    send(8'hF0); send(8'hE0); send(8'h16);
    chk("brk_e0", bus.ascii_out, 8'h31);
    pop1();

    bus.rd_en = 1'b1;
    send(8'h16);
    bus.rd_en = 1'b0;
    chk("empty_pp", bus.fifo_count, 1);
    pop1();
    chk("empty_pp2", bus.fifo_count, 0);

    bus.code_in    = 8'h16;
    bus.code_valid = 1'b1;
    cyc();
    chk("ovf_c1", bus.fifo_count, 1);
    chk("ovf_o1", bus.overflow, 0);
    cyc();
    chk("ovf_c2", bus.fifo_count, 2);
    cyc();
    chk("ovf_c3", bus.fifo_count, 3);
    cyc();
    chk("ovf_c4", bus.fifo_count, 4);
    chk("ovf_o4", bus.overflow, 0);
    cyc();
    chk("ovf_c5", bus.fifo_count, 4);
    chk("ovf_o5", bus.overflow, 1);
    cyc();
    chk("ovf_c6", bus.fifo_count, 4);
    chk("ovf_o6", bus.overflow, 1);
    bus.code_valid = 1'b0;
    cyc();
    chk("ovf_clr", bus.overflow, 0);
    send(8'h12);
    bus.code_in    = 8'h16;
    bus.code_valid = 1'b1;
    bus.rd_en      = 1'b1;
    cyc();
    bus.code_valid = 1'b0;
    bus.rd_en      = 1'b0;
    chk("full_pp_c", bus.fifo_count, 4);
    chk("full_pp_o", bus.overflow, 0);
    repeat (3) begin
      chk("drain_31", bus.ascii_out, 8'h31);
      pop1();
    end
    chk("drain_21", bus.ascii_out, 8'h21);
    pop1();
    chk("drain_0", bus.fifo_count, 0);
    send(8'hF0);
    send(8'h12);

    send(8'hF0);
    repeat (7) cyc();
    send(8'h16);
    chk("tmo_early", bus.fifo_count, 0);
    send(8'hF0);
    repeat (8) cyc();
    send(8'h16);
    chk("tmo_count", bus.fifo_count, 1);
    chk("tmo_out", bus.ascii_out, 8'h31);
    pop1();

    send(8'h12);
    send(8'h16);
    send(8'hE0);
    chk("pre_rst_c", bus.fifo_count, 1);
    rst = 1'b1;
    #1;
    chk("arst_shift", bus.shift_active, 0);
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_valid", bus.ascii_valid, 0);
    cyc();
    rst = 1'b0;
    cyc();
    send(8'h16);
    chk("post_rst", bus.ascii_out, 8'h31);
    chk("post_cnt", bus.fifo_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sequences raw PS/2 set-2 scancode bytes into ASCII characters for the keyboard path. Sits between the PS/2 byte receiver and character consumers (UART echo, display). Tracks the make/break/extended prefix protocol and live shift state, and drives the combinational scancode lookup. Buffers decoded characters in a small FIFO with a read handshake.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1_000_000, idle cycles after a prefix byte before the sequence is abandoned; ≥2
- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- code_in  in  8  scancode byte from receiver; sampled only when code_valid=1
- code_valid  in  1  one-cycle strobe; one byte per strobe; may assert on consecutive cycles
- rd_en  in  1  consumer pop; ignored when ascii_valid=0
- ascii_out  out  8  FIFO head character; 8'h00 when empty
- ascii_valid  out  1  FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- shift_active  out  1  left or right shift currently held
- overflow  out  1  one-cycle pulse when a decoded character is dropped because the FIFO is full

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - 12 sets lshift; 59 sets rshift.
  - AA, FA, EE, FC, FE are ignored; no state change.
  - Any other byte is a make: run the lookup with shift=lshift|rshift. Non-zero result is pushed; 00 is discarded.
- BRK: 12 clears lshift; 59 clears rshift; any other byte is ignored. Always → IDLE.
- EXT: F0 → EXT_BRK. Any other byte (including 12, the fake shift) is ignored → IDLE.
- EXT_BRK: any byte ignored → IDLE.
- Typematic repeats (repeated makes while held) each push a character.
- Prefix byte E0 or F0 arriving in the wrong state (e.g. E0 in BRK): the byte is consumed as a normal byte for that state's rule, so BRK+E0 → IDLE.
- Timeout: an idle counter runs only in EXT, BRK and EXT_BRK. It resets on every code_valid. Reaching TIMEOUT_CYCLES → IDLE; shift flags are unchanged.
- FIFO:
  - Push, no pop, not full: store.
  - Push while full without pop: drop the character, pulse overflow.
  - Push and pop in the same cycle while full: both succeed; count unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - FSM = IDLE; lshift = rshift = 0; counter = 0.
  - FIFO empty, so ascii_valid = 0, ascii_out = 00, fifo_count = 0.
  - shift_active = 0, overflow = 0.
- Reset mid-sequence discards the prefix and all buffered characters.

## Timing
- All outputs are registered except ascii_out. ascii_out is the FIFO head read combinationally from registered storage and pointers.
- A make byte with code_valid high in cycle N becomes visible in cycle N+1: ascii_valid=1, ascii_out=char, fifo_count incremented.
- The shift byte in cycle N updates shift_active at N+1. A make in cycle N+1 uses the new shift value.
- Pop: rd_en=1 in cycle N with ascii_valid=1. The head advances and fifo_count decrements at N+1.
- overflow is high in cycle N+1 for a drop caused by the byte in cycle N.
- Timeout: the prefix byte in cycle N returns the FSM to IDLE by cycle N+TIMEOUT_CYCLES+1.

## Structure
- Shared package holds:
  - Scancode constants: SC_EXT=E0, SC_BREAK=F0, SC_LSHIFT=12, SC_RSHIFT=59, and the ignored-response codes AA/FA/EE/FC/FE.
  - The FSM state encoding.
- Sub-module: the existing combinational lookup `ps2_to_ascii` (char_in, shift → ascii), instantiated once. No new lookup logic in this block.
- The FIFO is inline (register array plus pointers). A separate FIFO module is not warranted at this depth.

## Test plan
- Reset → byte 16 → ascii_out=31, ascii_valid=1, fifo_count=1 next cycle; rd_en pop → fifo_count=0, ascii_out=00.
- Sequence 12, 16, F0 12:
  - shift_active=1 after 12.
  - The 16 make is looked up with shift=1.
  - shift_active=0 after F0 12.
  - Sequence 59, F0 59 behaves the same for rshift.
- Sequence E0 12, E0 F0 12, E0 16 → nothing pushed, shift_active stays 0, FSM back to IDLE.
- Six consecutive 16 makes with FIFO_DEPTH=4 and no pops:
  - fifo_count saturates at 4.
  - overflow pulses on the 5th and 6th makes.
  - A full FIFO with simultaneous pop+push keeps fifo_count=4 with no overflow.
- Byte F0, then no bytes for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=8), then 16 → 31 pushed (16 treated as a make, not a break).
- Bytes 12, then E0, then rst asserted mid-sequence:
  - Immediate asynchronous clear: shift_active=0, fifo_count=0.
  - After release, 16 → 31.
